// File: rtl/hex_display_decoder_if.sv
// Bus bundle between a multiplexed 7-segment bank and its receive-side decoder.
interface hex_display_decoder_if;
    logic [7:0]  hex_seg_i;   // segments, active-low; bit0=a .. bit6=g, bit7=dp
    logic [3:0]  hex_grid_i;  // digit enables, active-low one-hot; bit3 = leftmost digit
    logic [15:0] value_o;     // last published display value
    logic [3:0]  dp_o;        // published decimal points, active-high
    logic        valid_o;     // one-cycle pulse on publish
    logic        bad_o;       // one-cycle pulse on a non-hex segment pattern

    // Display driver side (or a bench standing in for it)
    modport master (
        output hex_seg_i, hex_grid_i,
        input  value_o, dp_o, valid_o, bad_o
    );

    // Decoder side
    modport slave (
        input  hex_seg_i, hex_grid_i,
        output value_o, dp_o, valid_o, bad_o
    );
endinterface

// File: rtl/hex_display_decoder.sv
// Rebuilds the 16-bit value shown on one multiplexed 4-digit 7-segment bank.
// A digit is captured once {seg,grid} has held steady for SETTLE_CYCLES; four
// distinct digit captures form a frame, and a frame is published after
// STABLE_FRAMES identical frames in a row.
module hex_display_decoder #(
    parameter int unsigned SETTLE_CYCLES = 4,  // 1..15
    parameter int unsigned STABLE_FRAMES = 2   // 1..7
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_display_decoder_if.slave  bus
);

    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYCLES);
    localparam logic [2:0] STABLE_MAX = 3'(STABLE_FRAMES);

    // Active-high abcdefg pattern -> {ok, nibble}
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Active-low one-hot grid -> {ok, digit index}; blank or multi-select is not ok
    function automatic logic [2:0] decode_grid(input logic [3:0] g);
        logic [2:0] r;
        case (g)
            4'b0111: r = 3'b111;
            4'b1011: r = 3'b110;
            4'b1101: r = 3'b101;
            4'b1110: r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Input stage and settle tracking
    logic [7:0]  seg_q;
    logic [3:0]  grid_q;
    logic [3:0]  settle_q, settle_d;
    logic        strobe_q, strobe_d;
    logic        in_change;

    // Capture / frame state
    logic [15:0] nib_q, nib_d;
    logic [3:0]  dpb_q, dpb_d;
    logic [3:0]  seen_q, seen_d;
    logic [19:0] last_q, last_d;
    logic [2:0]  match_q, match_d;
    logic        pub_q, pub_d;

    // Published outputs
    logic [15:0] value_q, value_d;
    logic [3:0]  dp_q, dp_d;
    logic        valid_q, valid_d;
    logic        bad_q, bad_d;

    // Decode helpers
    logic [4:0]  seg_dec;
    logic [2:0]  grid_dec;
    logic [1:0]  idx;
    logic [19:0] frame;

    assign seg_dec  = decode_seg(~seg_q[6:0]);
    assign grid_dec = decode_grid(grid_q);
    assign idx      = grid_dec[1:0];

    // Settle counter next state and the single-cycle capture strobe.
    // A change of {seg_q,grid_q} is seen one edge early by comparing against
    // the raw inputs, so the counter clears on the same edge seg_q/grid_q move.
    always_comb begin
        in_change = ({bus.hex_seg_i, bus.hex_grid_i} != {seg_q, grid_q});
        settle_d  = settle_q;
        strobe_d  = 1'b0;
        if (in_change) begin
            settle_d = '0;
        end else if (settle_q != SETTLE_MAX) begin
            settle_d = settle_q + 4'd1;
            strobe_d = (settle_d == SETTLE_MAX);
        end
    end

    // Input registers, settle counter and strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q    <= '1;
            grid_q   <= '1;
            settle_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            seg_q    <= bus.hex_seg_i;
            grid_q   <= bus.hex_grid_i;
            settle_q <= settle_d;
            strobe_q <= strobe_d;
        end
    end

    // Digit capture, frame assembly, frame matching and publish decision
    always_comb begin
        nib_d   = nib_q;
        dpb_d   = dpb_q;
        seen_d  = seen_q;
        last_d  = last_q;
        match_d = match_q;
        pub_d   = pub_q;
        value_d = value_q;
        dp_d    = dp_q;
        valid_d = 1'b0;
        bad_d   = 1'b0;
        frame   = {nib_q, dpb_q};

        if (strobe_q && grid_dec[2]) begin
            if (!seg_dec[4]) begin
                // Non-hex pattern: drop the partial frame, keep match history
                bad_d  = 1'b1;
                seen_d = '0;
            end else begin
                nib_d[{idx, 2'b00} +: 4] = seg_dec[3:0];
                dpb_d[idx]               = ~seg_q[7];
                seen_d                   = seen_q | (4'b0001 << idx);
                if (seen_d == 4'hF) begin
                    seen_d = '0;
                    frame  = {nib_d, dpb_d};
                    // match_q==0 means no frame recorded since reset
                    if ((match_q != 3'd0) && (frame == last_q)) begin
                        if (match_q != STABLE_MAX) begin
                            match_d = match_q + 3'd1;
                        end
                    end else begin
                        match_d = 3'd1;
                        last_d  = frame;
                    end
                    if ((match_d == STABLE_MAX) &&
                        (!pub_q || (frame != {value_q, dp_q}))) begin
                        value_d = frame[19:4];
                        dp_d    = frame[3:0];
                        valid_d = 1'b1;
                        pub_d   = 1'b1;
                    end
                end
            end
        end
    end

    // Frame state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            nib_q   <= '0;
            dpb_q   <= '0;
            seen_q  <= '0;
            last_q  <= '0;
            match_q <= '0;
            pub_q   <= 1'b0;
            value_q <= '0;
            dp_q    <= '0;
            valid_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            nib_q   <= nib_d;
            dpb_q   <= dpb_d;
            seen_q  <= seen_d;
            last_q  <= last_d;
            match_q <= match_d;
            pub_q   <= pub_d;
            value_q <= value_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
            bad_q   <= bad_d;
        end
    end

    assign bus.value_o = value_q;
    assign bus.dp_o    = dp_q;
    assign bus.valid_o = valid_q;
    assign bus.bad_o   = bad_q;

endmodule

// File: tb/tb_hex_display_decoder.sv
// Directed bench for hex_display_decoder: a table of display steps with the
// pulses and outputs expected at the end of each, plus hand-written reset and
// latency sequences.
module tb_hex_display_decoder;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   vcnt;
    int   bcnt;

    hex_display_decoder_if bus_if();

    hex_display_decoder #(
        .SETTLE_CYCLES(4),
        .STABLE_FRAMES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low segment codes, dp off
    localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0;
    localparam logic [7:0] S4 = 8'h99, S5 = 8'h92, S6 = 8'h82, S7 = 8'hF8;
    localparam logic [7:0] S8 = 8'h80, S9 = 8'h90, SA = 8'h88, SB = 8'h83;
    localparam logic [7:0] SC = 8'hC6, SD = 8'hA1, SOFF = 8'hFF;
    localparam logic [7:0] S6DP = 8'h02;   // digit 6 with its decimal point lit

    typedef struct {
        logic [7:0]  seg;
        logic [3:0]  grid;
        int          cyc;
        int          ev;    // valid_o pulses expected during this step
        int          eb;    // bad_o pulses expected during this step
        logic [15:0] val;   // value_o at end of step
        logic [3:0]  dp;    // dp_o at end of step
    } step_t;

    step_t steps[$];

    // Pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        if (bus_if.valid_o) vcnt = vcnt + 1;
        if (bus_if.bad_o)   bcnt = bcnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_step(input logic [7:0] seg, input logic [3:0] grid, input int cyc,
                            input int ev, input int eb, input logic [15:0] val,
                            input logic [3:0] dp);
        step_t s;
        s.seg = seg; s.grid = grid; s.cyc = cyc; s.ev = ev; s.eb = eb;
        s.val = val; s.dp = dp;
        steps.push_back(s);
    endtask

    // One full scan, leftmost digit first; only the last digit can publish
    task automatic add_frame(input logic [7:0] s3, input logic [7:0] s2,
                             input logic [7:0] s1, input logic [7:0] s0,
                             input int ev, input logic [15:0] v_before,
                             input logic [15:0] v_after, input logic [3:0] dp_before,
                             input logic [3:0] dp_after);
        add_step(s3, 4'b0111, 10, 0, 0, v_before, dp_before);
        add_step(s2, 4'b1011, 10, 0, 0, v_before, dp_before);
        add_step(s1, 4'b1101, 10, 0, 0, v_before, dp_before);
        add_step(s0, 4'b1110, 10, ev, 0, v_after, dp_after);
    endtask

    task automatic drive(input logic [7:0] seg, input logic [3:0] grid, input int cyc);
        bus_if.hex_seg_i  = seg;
        bus_if.hex_grid_i = grid;
        repeat (cyc) @(negedge clk);
        #1;
    endtask

    initial begin
        int v0, b0;
        errors = 0;
        checks = 0;
        vcnt   = 0;
        bcnt   = 0;
        reset  = 1'b1;
        bus_if.hex_seg_i  = SOFF;
        bus_if.hex_grid_i = 4'hF;

        // Reset held 10 cycles: all outputs low throughout
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check($sformatf("reset_out[%0d]", i),
                  {10'd0, bus_if.value_o, bus_if.dp_o, bus_if.valid_o, bus_if.bad_o}, 32'd0);
        end
        reset = 1'b0;
        drive(SOFF, 4'hF, 8);
        check("idle_no_pulse", vcnt + bcnt, 0);

        // 1234 twice -> one publish; three more frames -> silence
        add_frame(S1, S2, S3, S4, 0, 16'h0000, 16'h0000, 4'h0, 4'h0);
        add_frame(S1, S2, S3, S4, 1, 16'h0000, 16'h1234, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++)
            add_frame(S1, S2, S3, S4, 0, 16'h1234, 16'h1234, 4'h0, 4'h0);
        // Switch to 009C: publishes after its second frame
        add_frame(S0, S0, S9, SC, 0, 16'h1234, 16'h1234, 4'h0, 4'h0);
        add_frame(S0, S0, S9, SC, 1, 16'h1234, 16'h009C, 4'h0, 4'h0);
        // Short 3-cycle glitch on the leftmost digit must not be captured
        for (int i = 0; i < 2; i++) begin
            add_step(S0, 4'b0111, 10, 0, 0, 16'h009C, 4'h0);
            add_step(S0, 4'b1011, 10, 0, 0, 16'h009C, 4'h0);
            add_step(S1, 4'b0111,  3, 0, 0, 16'h009C, 4'h0);
            add_step(S9, 4'b1101, 10, 0, 0, 16'h009C, 4'h0);
            add_step(SC, 4'b1110, 10, 0, 0, 16'h009C, 4'h0);
        end
        // 5678 once, then a partial frame killed by a blank digit; the
        // match count survives, so the next complete frame publishes
        add_frame(S5, S6DP, S7, S8, 0, 16'h009C, 16'h009C, 4'h0, 4'h0);
        add_step(S5,   4'b0111, 10, 0, 0, 16'h009C, 4'h0);
        add_step(S6DP, 4'b1011, 10, 0, 0, 16'h009C, 4'h0);
        add_step(S7,   4'b1101, 10, 0, 0, 16'h009C, 4'h0);
        add_step(SOFF, 4'b1110, 10, 0, 1, 16'h009C, 4'h0);
        add_step(S8,   4'b1110, 10, 0, 0, 16'h009C, 4'h0);
        add_step(S5,   4'b0111, 10, 0, 0, 16'h009C, 4'h0);
        add_step(S6DP, 4'b1011, 10, 0, 0, 16'h009C, 4'h0);
        add_step(S7,   4'b1101, 10, 1, 0, 16'h5678, 4'b0100);
        add_step(S8,   4'b1110, 10, 0, 0, 16'h5678, 4'b0100);

        foreach (steps[i]) begin
            v0 = vcnt;
            b0 = bcnt;
            drive(steps[i].seg, steps[i].grid, steps[i].cyc);
            check($sformatf("step%0d_valid_pulses", i), vcnt - v0, steps[i].ev);
            check($sformatf("step%0d_bad_pulses", i), bcnt - b0, steps[i].eb);
            check($sformatf("step%0d_value", i), {16'd0, bus_if.value_o}, {16'd0, steps[i].val});
            check($sformatf("step%0d_dp", i), {28'd0, bus_if.dp_o}, {28'd0, steps[i].dp});
        end

        // ABCD once, three digits of the second frame, then reset
        drive(SA, 4'b0111, 10); drive(SB, 4'b1011, 10);
        drive(SC, 4'b1101, 10); drive(SD, 4'b1110, 10);
        drive(SA, 4'b0111, 10); drive(SB, 4'b1011, 10);
        drive(SC, 4'b1101, 10);
        reset = 1'b1;
        bus_if.hex_seg_i  = SOFF;
        bus_if.hex_grid_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("midreset_out[%0d]", i),
                  {10'd0, bus_if.value_o, bus_if.dp_o, bus_if.valid_o, bus_if.bad_o}, 32'd0);
        end
        reset = 1'b0;
        drive(SOFF, 4'hF, 6);

        // First fresh frame after reset must not publish
        v0 = vcnt;
        drive(SA, 4'b0111, 10); drive(SB, 4'b1011, 10);
        drive(SC, 4'b1101, 10); drive(SD, 4'b1110, 10);
        check("postreset_frame1_no_valid", vcnt - v0, 0);
        check("postreset_value_zero", {16'd0, bus_if.value_o}, 32'd0);

        // Second frame: valid_o exactly 1 + SETTLE + 1 edges after the last digit
        drive(SA, 4'b0111, 10); drive(SB, 4'b1011, 10); drive(SC, 4'b1101, 10);
        v0 = vcnt;
        bus_if.hex_seg_i  = SD;
        bus_if.hex_grid_i = 4'b1110;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); #1;
            check($sformatf("latency_valid_edge%0d", k), {31'd0, bus_if.valid_o},
                  (k == 6) ? 32'd1 : 32'd0);
        end
        drive(SD, 4'b1110, 4);
        check("postreset_frame2_one_valid", vcnt - v0, 1);
        check("postreset_value", {16'd0, bus_if.value_o}, 32'h0000ABCD);
        check("postreset_dp", {28'd0, bus_if.dp_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
